cpu_step_ctrl: RTL and testbench

Execution-rate controller between the board clock domain and the CPU core. It debounces the step pushbutton and synchronizes the run switch. It then issues one-clock `cpu_ena` pulses: one per button press in single-step mode, or one every `RUN_PERIOD` clocks in free-run mode. A 32-bit count of issued pulses drives a spare input of the board display multiplexer so instruction progress is visible on the 7-segment display.

---
 rtl/cpu_step_ctrl.sv | 118 +++++++++++
 tb/tb_cpu_step_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/cpu_step_ctrl.sv
// Execution-rate controller: debounces the step button, synchronizes the run switch,
// and issues one-clock cpu_ena pulses (per press in STEP, every RUN_PERIOD clocks in RUN).
module cpu_step_ctrl #(
    parameter int DB_CYCLES  = 1000000,
    parameter int RUN_PERIOD = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        btn_step,
    input  logic        run,
    output logic        cpu_ena,
    output logic [31:0] step_cnt,
    output logic        btn_level,
    output logic        running
);

    localparam int DB_W  = $clog2(DB_CYCLES + 1);
    localparam int PRE_W = $clog2(RUN_PERIOD + 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RUN_PERIOD - 1);

    typedef enum logic {
        STEP = 1'b0,
        RUN  = 1'b1
    } mode_t;

    logic              b1_r, b2_r, r1_r;
    mode_t             mode_r, mode_s;
    logic              btn_level_r, btn_level_s;
    logic              btn_prev_r;
    logic [DB_W-1:0]   db_cnt_r, db_cnt_s;
    logic [PRE_W-1:0]  pre_r, pre_s;
    logic              cpu_ena_r, cpu_ena_s;
    logic [31:0]       step_cnt_r, step_cnt_s;
    logic              rise_s;

    // Debouncer: accept b2 only after it differs from the current level for DB_CYCLES edges
    always_comb begin
        db_cnt_s    = db_cnt_r;
        btn_level_s = btn_level_r;
        if (b2_r == btn_level_r) begin
            db_cnt_s = {DB_W{1'b0}};
        end else if (db_cnt_r == DB_LAST) begin
            btn_level_s = b2_r;
            db_cnt_s    = {DB_W{1'b0}};
        end else begin
            db_cnt_s = db_cnt_r + DB_W'(1);
        end
    end

    // Mode FSM next state and pulse generation; the mode register is the second run sync stage
    always_comb begin
        mode_s    = r1_r ? RUN : STEP;
        rise_s    = btn_level_r & ~btn_prev_r;
        pre_s     = pre_r;
        cpu_ena_s = 1'b0;
        case (mode_r)
            STEP: begin
                pre_s     = {PRE_W{1'b0}};
                cpu_ena_s = rise_s & ena;
            end
            RUN: begin
                // Button edges are deliberately dropped here, not queued for later
                if (ena) begin
                    if (pre_r == PRE_LAST) begin
                        pre_s     = {PRE_W{1'b0}};
                        cpu_ena_s = 1'b1;
                    end else begin
                        pre_s     = pre_r + PRE_W'(1);
                        cpu_ena_s = 1'b0;
                    end
                end else begin
                    pre_s     = pre_r;
                    cpu_ena_s = 1'b0;
                end
            end
            default: begin
                pre_s     = {PRE_W{1'b0}};
                cpu_ena_s = 1'b0;
            end
        endcase
        step_cnt_s = cpu_ena_s ? (step_cnt_r + 32'd1) : step_cnt_r;
    end

    // State registers: synchronizers, debouncer, edge detect, prescaler, pulse and counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b1_r        <= 1'b0;
            b2_r        <= 1'b0;
            r1_r        <= 1'b0;
            mode_r      <= STEP;
            btn_level_r <= 1'b0;
            btn_prev_r  <= 1'b0;
            db_cnt_r    <= {DB_W{1'b0}};
            pre_r       <= {PRE_W{1'b0}};
            cpu_ena_r   <= 1'b0;
            step_cnt_r  <= 32'd0;
        end else begin
            b1_r        <= btn_step;
            b2_r        <= b1_r;
            r1_r        <= run;
            mode_r      <= mode_s;
            btn_level_r <= btn_level_s;
            btn_prev_r  <= btn_level_r;
            db_cnt_r    <= db_cnt_s;
            pre_r       <= pre_s;
            cpu_ena_r   <= cpu_ena_s;
            step_cnt_r  <= step_cnt_s;
        end
    end

    assign cpu_ena   = cpu_ena_r;
    assign step_cnt  = step_cnt_r;
    assign btn_level = btn_level_r;
    assign running   = (mode_r == RUN);

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with DB_CYCLES=4, RUN_PERIOD=3: a vector table for
// STEP-mode debounce behaviour, then hand-written RUN, ena-gap, wrap and reset sequences.
module tb_cpu_step_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b1;
    logic        btn_step = 1'b0;
    logic        run = 1'b0;
    logic        cpu_ena;
    logic [31:0] step_cnt;
    logic        btn_level;
    logic        running;

    int passed = 0;
    int total  = 0;

    cpu_step_ctrl #(.DB_CYCLES(4), .RUN_PERIOD(3)) dut (
        .clk(clk), .rst(rst), .ena(ena), .btn_step(btn_step), .run(run),
        .cpu_ena(cpu_ena), .step_cnt(step_cnt), .btn_level(btn_level), .running(running)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ena;
        logic        btn;
        logic        run;
        int          n;
        logic        ce;
        logic        lvl;
        logic        rn;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act === exp_v) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp_v);
    endtask

    task automatic chk_all(input string nm, input logic ce, input logic lvl,
                           input logic rn, input logic [31:0] cnt);
        chk({nm, " cpu_ena"},   {31'd0, cpu_ena},   {31'd0, ce});
        chk({nm, " btn_level"}, {31'd0, btn_level}, {31'd0, lvl});
        chk({nm, " running"},   {31'd0, running},   {31'd0, rn});
        chk({nm, " step_cnt"},  step_cnt,           cnt);
    endtask

    initial begin
        // {ena, btn, run, cycles, exp cpu_ena, exp btn_level, exp running, exp step_cnt}
        // Clean press before edge 1: level after edge 6, pulse after edge 7
        vecs.push_back('{1'b1, 1'b1, 1'b0, 5, 1'b0, 1'b0, 1'b0, 32'd0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0, 32'd0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0, 32'd1});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0, 32'd1});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b1, 1'b0, 32'd1});
        // Release before edge 11: level drops after edge 16, no pulse
        vecs.push_back('{1'b1, 1'b0, 1'b0, 5, 1'b0, 1'b1, 1'b0, 32'd1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 32'd1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 32'd1});
        // Bounce: high 2, low 1, high 3, low
        vecs.push_back('{1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 32'd1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 32'd1});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0, 32'd1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 6, 1'b0, 1'b0, 1'b0, 32'd1});
        // 6-cycle stable press
        vecs.push_back('{1'b1, 1'b1, 1'b0, 5, 1'b0, 1'b0, 1'b0, 32'd1});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0, 32'd1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 32'd2});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0, 32'd2});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0, 32'd2});
        // Press with ena low is discarded, not deferred once ena returns
        vecs.push_back('{1'b0, 1'b1, 1'b0, 6, 1'b0, 1'b1, 1'b0, 32'd2});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0, 32'd2});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b1, 1'b0, 32'd2});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 7, 1'b0, 1'b0, 1'b0, 32'd2});

        #2;
        chk_all("reset", 1'b0, 1'b0, 1'b0, 32'd0);
        tick(); tick(); tick();
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            ena      = vecs[i].ena;
            btn_step = vecs[i].btn;
            run      = vecs[i].run;
            repeat (vecs[i].n) tick();
            chk_all($sformatf("vec%0d", i), vecs[i].ce, vecs[i].lvl, vecs[i].rn, vecs[i].cnt);
        end

        // Free-run: run_s rises two edges after run, pulses every third edge after that
        run = 1'b1;
        tick();
        chk("run sync stage1", {31'd0, running}, 32'd0);
        tick();
        chk("run sync stage2", {31'd0, running}, 32'd1);
        for (int i = 1; i <= 18; i++) begin
            if (i == 5) btn_step = 1'b1;
            tick();
            chk($sformatf("run r+%0d cpu_ena", i), {31'd0, cpu_ena}, {31'd0, (i % 3 == 0)});
            chk($sformatf("run r+%0d step_cnt", i), step_cnt, 32'd2 + 32'(i / 3));
        end
        chk("run btn debounced", {31'd0, btn_level}, 32'd1);

        // ena gap while pre = 1: prescaler holds, next pulse two edges after ena returns
        btn_step = 1'b0;
        tick();
        chk("gap pre1 cpu_ena", {31'd0, cpu_ena}, 32'd0);
        ena = 1'b0;
        for (int j = 0; j < 5; j++) begin
            tick();
            chk($sformatf("gap %0d cpu_ena", j), {31'd0, cpu_ena}, 32'd0);
        end
        chk("gap step_cnt", step_cnt, 32'd8);
        ena = 1'b1;
        tick();
        chk("resume +1 cpu_ena", {31'd0, cpu_ena}, 32'd0);
        tick();
        chk("resume +2 cpu_ena", {31'd0, cpu_ena}, 32'd1);
        chk("resume +2 step_cnt", step_cnt, 32'd9);

        // Back to STEP: no pulse on the way out
        run = 1'b0;
        tick();
        chk("leave run stage1", {31'd0, running}, 32'd1);
        tick();
        chk("leave run stage2", {31'd0, running}, 32'd0);
        repeat (4) tick();
        chk_all("step idle", 1'b0, 1'b0, 1'b0, 32'd9);

        // Counter wrap
        force dut.step_cnt_r = 32'hFFFF_FFFF;
        #1;
        release dut.step_cnt_r;
        chk("forced step_cnt", step_cnt, 32'hFFFF_FFFF);
        btn_step = 1'b1;
        repeat (6) tick();
        chk_all("wrap pre", 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF);
        tick();
        chk_all("wrap pulse", 1'b1, 1'b1, 1'b0, 32'd0);
        tick();
        chk_all("wrap after", 1'b0, 1'b1, 1'b0, 32'd0);

        // Async reset mid-count in RUN with the button held
        run = 1'b1;
        repeat (3) tick();
        chk("pre-reset running", {31'd0, running}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk_all("async reset", 1'b0, 1'b0, 1'b0, 32'd0);
        run = 1'b0;
        tick(); tick();
        chk_all("held reset", 1'b0, 1'b0, 1'b0, 32'd0);
        rst = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk($sformatf("post-reset e%0d cpu_ena", i), {31'd0, cpu_ena}, {31'd0, (i == 7)});
            chk($sformatf("post-reset e%0d step_cnt", i), step_cnt, (i >= 7) ? 32'd1 : 32'd0);
        end
        chk("post-reset level", {31'd0, btn_level}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
